// File: rtl/mat_mul_pkg.sv
// Shared constants and state encoding for the serial 4x4 by 4x2 matrix multiply sequencer.
package mat_mul_pkg;

   localparam int unsigned DW      = 16;
   localparam int unsigned A_WORDS = 16;
   localparam int unsigned B_WORDS = 8;
   localparam int unsigned S_WORDS = 8;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_CALC  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/mul2vector4x1.sv
// Combinational 4-element signed dot product, result wrapped to DW bits.
module mul2vector4x1 #(
   parameter int unsigned DW = 16
) (
   input  logic [3:0][DW-1:0] i_a,
   input  logic [3:0][DW-1:0] i_b,
   output logic [DW-1:0]      o_dot
);

   logic [DW-1:0] w_sum;

   // Only the low DW bits survive, and those do not depend on the width the products are formed in.
   always_comb begin
      w_sum = '0;
      for (int j = 0; j < 4; j++) begin
         w_sum = w_sum + DW'($signed(i_a[j]) * $signed(i_b[j]));
      end
   end

   assign o_dot = w_sum;

endmodule

// File: rtl/mat_mul_seq_ctrl.sv
// Loads A(4x4) and B(4x2) as a word stream, then emits S = A x B one element per cycle
// through a single shared dot-product unit.
module mat_mul_seq_ctrl
   import mat_mul_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [2:0]    out_idx,
   output logic          out_last,
   output logic          busy,
   output logic          done
);

   localparam logic [4:0] LAST_WORD = 5'(A_WORDS + B_WORDS - 1);
   localparam logic [4:0] FIRST_B   = 5'(A_WORDS);

   state_t              r_state;
   state_t              w_state_next;
   logic [4:0]          r_wcnt;
   logic [2:0]          r_k;
   logic [DW-1:0]       r_a [A_WORDS];
   logic [DW-1:0]       r_b [B_WORDS];
   logic [DW-1:0]       r_out_data;
   logic                r_out_valid;
   logic                r_done;

   logic                w_in_hs;
   logic                w_out_hs;
   logic [2:0]          w_sel_k;
   logic [1:0]          w_row;
   logic                w_col;
   logic [3:0][DW-1:0]  w_a_row;
   logic [3:0][DW-1:0]  w_b_col;
   logic [DW-1:0]       w_dot;

   assign w_in_hs  = in_valid && in_ready;
   assign w_out_hs = r_out_valid && out_ready;

   // Select the element that will be registered on this edge, not the one being shown.
   assign w_sel_k = (r_state == ST_CALC) ? 3'd0 : r_k + 3'd1;
   assign w_row   = w_sel_k[2:1];
   assign w_col   = w_sel_k[0];

   always_comb begin
      for (int j = 0; j < 4; j++) begin
         w_a_row[j] = r_a[{w_row, 2'(j)}];
         w_b_col[j] = r_b[{2'(j), w_col}];
      end
   end

   mul2vector4x1 #(
      .DW (DW)
   ) u_dot (
      .i_a   (w_a_row),
      .i_b   (w_b_col),
      .o_dot (w_dot)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_LOAD:  if (w_in_hs && (r_wcnt == LAST_WORD)) w_state_next = ST_CALC;
         ST_CALC:  w_state_next = ST_DRAIN;
         ST_DRAIN: if (w_out_hs && (r_k == 3'd7)) w_state_next = ST_LOAD;
         default:  w_state_next = ST_LOAD;
      endcase
   end

   always_comb begin
      in_ready = (r_state == ST_LOAD);
      busy     = (r_state == ST_CALC) || (r_state == ST_DRAIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wcnt      <= '0;
         r_k         <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         for (int i = 0; i < int'(A_WORDS); i++) r_a[i] <= '0;
         for (int i = 0; i < int'(B_WORDS); i++) r_b[i] <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_LOAD: begin
               if (w_in_hs) begin
                  if (r_wcnt < FIRST_B) r_a[r_wcnt[3:0]] <= in_data;
                  else                  r_b[r_wcnt[2:0]] <= in_data;
                  r_wcnt <= (r_wcnt == LAST_WORD) ? 5'd0 : r_wcnt + 5'd1;
               end
            end
            ST_CALC: begin
               r_out_data  <= w_dot;
               r_out_valid <= 1'b1;
               r_k         <= 3'd0;
            end
            ST_DRAIN: begin
               if (w_out_hs) begin
                  if (r_k == 3'd7) begin
                     r_out_valid <= 1'b0;
                     r_done      <= 1'b1;
                     r_k         <= 3'd0;
                  end else begin
                     r_k        <= w_sel_k;
                     r_out_data <= w_dot;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_idx   = r_k;
   assign out_last  = r_out_valid && (r_k == 3'd7);
   assign done      = r_done;

endmodule

// File: tb/tb_mat_mul_seq_ctrl.sv
// Directed and randomized checks of mat_mul_seq_ctrl against a plain-arithmetic matrix model.
module tb_mat_mul_seq_ctrl;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [2:0]    out_idx;
   logic          out_last;
   logic          busy;
   logic          done;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] words [24];
   logic [DW-1:0] exp_s [8];

   always #5 clk = ~clk;

   mat_mul_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // S[r][c] = sum_j A[r][j]*B[j][c], with A row-major in words[0..15], B row-major in words[16..23].
   function automatic void build_model();
      for (int k = 0; k < 8; k++) begin
         int r = k / 2;
         int c = k % 2;
         logic signed [63:0] s = 0;
         for (int j = 0; j < 4; j++) begin
            s += longint'($signed(words[4*r + j])) * longint'($signed(words[16 + 2*j + c]));
         end
         exp_s[k] = s[DW-1:0];
      end
   endfunction

   function automatic void random_words();
      for (int i = 0; i < 24; i++) words[i] = DW'($urandom);
      build_model();
   endfunction

   // Feed words; stop_at<0 loads all 24 and checks CALC latency, else stops with word stop_at-1 pending.
   task automatic load(input int gap_pct, input int stop_at);
      int i = 0;
      int cyc = 0;
      int n = (stop_at < 0) ? 24 : stop_at;
      while (i < n && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         chk("in_ready_load", in_ready, 1);
         if (int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
         end else begin
            in_valid = 1'b1;
            in_data  = words[i];
            if (in_ready) i++;
         end
      end
      chk("load_words_accepted", i, n);
      if (stop_at < 0) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = DW'($urandom);
         chk("calc_out_valid", out_valid, 0);
         chk("calc_busy", busy, 1);
         chk("calc_in_ready", in_ready, 0);
         @(negedge clk);
         chk("first_valid_2_edges", out_valid, 1);
      end
   endtask

   // mode 0: always ready, 1: 5-cycle stall at idx 2 then random, 2: random.
   task automatic collect(input int mode, input int abort_idx);
      int cnt = 0;
      int cyc = 0;
      int stall = 0;
      while (cnt < 8 && cyc < 3000) begin
         cyc++;
         if (out_valid) begin
            chk("out_idx", out_idx, cnt);
            chk("out_data", out_data, exp_s[cnt]);
            chk("out_last", out_last, (cnt == 7));
            chk("in_ready_drain", in_ready, 0);
            chk("busy_drain", busy, 1);
            chk("done_drain", done, 0);
            if (abort_idx == cnt) begin
               rst       = 1'b1;
               out_ready = 1'b1;
               @(negedge clk);
               chk("rst_mid_out_valid", out_valid, 0);
               chk("rst_mid_in_ready", in_ready, 1);
               chk("rst_mid_busy", busy, 0);
               rst       = 1'b0;
               out_ready = 1'b0;
               return;
            end
            if (mode == 0) begin
               out_ready = 1'b1;
            end else if (mode == 1 && cnt == 2 && stall < 5) begin
               out_ready = 1'b0;
               stall++;
            end else begin
               out_ready = 1'($urandom);
            end
            if (out_ready) cnt++;
         end else begin
            chk("drain_out_valid", out_valid, 1);
            break;
         end
         @(negedge clk);
      end
      chk("results_delivered", cnt, 8);
      out_ready = 1'b0;
      chk("done_pulse", done, 1);
      chk("out_valid_after_s7", out_valid, 0);
      chk("out_last_after_s7", out_last, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("in_ready_back", in_ready, 1);
      chk("busy_after", busy, 0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      rst = 1'b0;

      // Identity A, B = 1..8
      for (int i = 0; i < 16; i++) words[i] = (i / 4 == i % 4) ? DW'(1) : DW'(0);
      for (int i = 0; i < 8; i++) words[16 + i] = DW'(i + 1);
      build_model();
      load(0, -1);
      collect(0, -1);

      // Signed products
      for (int i = 0; i < 16; i++) words[i] = 16'hFFFF;
      words[16] = DW'(1);  words[17] = DW'(-2);
      words[18] = DW'(3);  words[19] = DW'(0);
      words[20] = DW'(-5); words[21] = DW'(4);
      words[22] = DW'(2);  words[23] = DW'(2);
      build_model();
      load(0, -1);
      collect(0, -1);

      // Wrap: 0x4000 * 0x4000 truncates to zero
      for (int i = 0; i < 24; i++) words[i] = '0;
      words[0]  = 16'h4000;
      words[16] = 16'h4000;
      build_model();
      load(0, -1);
      collect(0, -1);

      // Backpressure
      random_words();
      load(0, -1);
      collect(1, -1);

      // Input gaps with garbage data
      random_words();
      load(40, -1);
      collect(2, -1);

      // Reset during load, with a handshake coinciding with rst
      random_words();
      load(30, 10);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_load_out_valid", out_valid, 0);
      chk("rst_load_in_ready", in_ready, 1);
      chk("rst_load_busy", busy, 0);
      rst      = 1'b0;
      in_valid = 1'b0;
      random_words();
      load(0, -1);
      collect(2, -1);

      // Reset during drain
      random_words();
      load(0, -1);
      collect(0, 3);
      random_words();
      load(20, -1);
      collect(2, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
